mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Sequences one neuron evaluation: walks NUM_GROUPS 4-bit spike groups,
//   fetches the 128-bit weight word for each non-empty group, feeds spikes
//   and weights to an external combinational MAC and accumulates its result
//   (modulo 2^32). Groups with no spikes are skipped without a memory read.
//
// Ports
//   CLK, RESET     clock, synchronous active-high reset
//   start          request an evaluation (accepted only in IDLE)
//   spike_vector   presynaptic spikes, group g = bits [4g+3:4g]
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle pulse, acc_out is final while it is high
//   acc_out        accumulated membrane contribution, held until next done
//   weight_rd_en   one-cycle weight-memory read strobe
//   weight_addr    weight-memory read address (BASE_ADDR + group)
//   weight_data    four 32-bit weights, lane i = bits [32i+31:32i]
//   weight_valid   weight_data valid; only observed in WAIT
//   mac_spike      spike group presented to the MAC (zero outside ACCUM)
//   mac_weights    captured weights presented to the MAC (zero outside ACCUM)
//   mac_result     MAC output, sum of lanes whose spike bit is set
module mac_sequencer #(
    parameter int NUM_GROUPS = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [4*NUM_GROUPS-1:0]   spike_vector,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               acc_out,
    output logic                      weight_rd_en,
    output logic [ADDR_WIDTH-1:0]     weight_addr,
    input  logic [127:0]              weight_data,
    input  logic                      weight_valid,
    output logic [3:0]                mac_spike,
    output logic [127:0]              mac_weights,
    input  logic [31:0]               mac_result
);

    localparam int G_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ACCUM,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [G_W-1:0]          g;
    logic [G_W-1:0]          g_n;
    logic [4*NUM_GROUPS-1:0] spikes_q;
    logic [4*NUM_GROUPS-1:0] spikes_n;
    logic [31:0]             acc;
    logic [3:0]              cur_group;
    logic [3:0]              next_group;
    logic                    last_group;
    logic                    issue_n;

    assign cur_group  = spikes_q[4*int'(g) +: 4];
    assign next_group = spikes_n[4*int'(g_n) +: 4];
    assign last_group = (g == G_W'(NUM_GROUPS - 1));

    // Next-state view lets the read strobe and address be registered so that
    // they are high exactly during the issuing FETCH cycle.
    assign issue_n = (state_n == FETCH) && (next_group != 4'd0);

    always_comb begin
        state_n  = state;
        g_n      = g;
        spikes_n = spikes_q;
        case (state)
            IDLE: begin
                if (start) begin
                    spikes_n = spike_vector;
                    g_n      = '0;
                    state_n  = FETCH;
                end
            end
            FETCH: begin
                if (cur_group != 4'd0) begin
                    state_n = WAIT;
                end else if (last_group) begin
                    state_n = DONE;
                end else begin
                    g_n = g + G_W'(1);
                end
            end
            WAIT: begin
                if (weight_valid) begin
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (last_group) begin
                    state_n = DONE;
                end else begin
                    g_n     = g + G_W'(1);
                    state_n = FETCH;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            g            <= '0;
            spikes_q     <= '0;
            acc          <= '0;
            acc_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            weight_rd_en <= 1'b0;
            weight_addr  <= '0;
            mac_spike    <= '0;
            mac_weights  <= '0;
        end else begin
            state        <= state_n;
            g            <= g_n;
            spikes_q     <= spikes_n;
            busy         <= (state_n != IDLE);
            weight_rd_en <= issue_n;
            weight_addr  <= issue_n ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(g_n)) : '0;
            done         <= (state == DONE);

            if (state == IDLE && start) begin
                acc <= '0;
            end

            // mac_weights doubles as the captured weight register; it is only
            // non-zero for the single ACCUM cycle.
            if (state == WAIT && weight_valid) begin
                mac_spike   <= cur_group;
                mac_weights <= weight_data;
            end else if (state == ACCUM) begin
                mac_spike   <= '0;
                mac_weights <= '0;
            end

            if (state == ACCUM) begin
                acc <= acc + mac_result;
            end

            if (state == DONE) begin
                acc_out <= acc;
            end
        end
    end

endmodule
